// File: rtl/pps_gen.sv
// One-pulse-per-second generator with a per-second length trim fed through a
// valid/ready adjust port; also emits a tick strobe, seconds count and toggle flag.
module pps_gen #(
    parameter int unsigned PERIOD  = 300000000,
    parameter int unsigned MAX_ADJ = 150000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] width,
    input  logic        adj_valid,
    output logic        adj_ready,
    input  logic [31:0] adj_val,
    output logic        pps_out,
    output logic        tick,
    output logic        flag,
    output logic [31:0] sec_cnt,
    output logic [31:0] phase
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    localparam logic signed [32:0] MAX_S    = 33'(MAX_ADJ);
    localparam logic signed [32:0] PERIOD_S = 33'(PERIOD);

    state_t      state, state_nx;
    logic        pending, pending_nx;
    logic [31:0] pending_adj, pending_adj_nx;
    logic [32:0] per_cur, per_cur_nx;
    logic [31:0] width_cur, width_cur_nx;
    logic        pps_nx, tick_nx, flag_nx;
    logic [31:0] sec_cnt_nx, phase_nx;

    logic               xfer;
    logic               start;
    logic signed [32:0] adj_ext, adj_clamped, per_sum;
    logic [32:0]        per_new;
    logic [31:0]        width_new;

    // Handshake: a value transfers on any edge where adj_valid && adj_ready;
    // adj_ready is simply "no adjustment outstanding".
    assign adj_ready = ~pending;

    always_comb begin
        xfer    = adj_valid && !pending;
        adj_ext = {pending_adj[31], pending_adj};
        if (adj_ext > MAX_S)
            adj_clamped = MAX_S;
        else if (adj_ext < -MAX_S)
            adj_clamped = -MAX_S;
        else
            adj_clamped = adj_ext;
        per_sum = PERIOD_S + adj_clamped;
        per_new = pending ? per_sum : PERIOD_S;
        // Keep at least one low cycle so the pulse never merges with the next tick.
        if ({1'b0, width} >= per_new)
            width_new = 32'(per_new - 33'd1);
        else
            width_new = width;
    end

    always_comb begin
        state_nx       = state;
        pps_nx         = pps_out;
        tick_nx        = 1'b0;
        flag_nx        = flag;
        sec_cnt_nx     = sec_cnt;
        phase_nx       = phase;
        per_cur_nx     = per_cur;
        width_cur_nx   = width_cur;
        pending_adj_nx = xfer ? adj_val : pending_adj;
        start          = 1'b0;

        case (state)
            IDLE: begin
                pps_nx   = 1'b0;
                phase_nx = 32'd0;
                if (en)
                    start = 1'b1;
            end
            HIGH: begin
                phase_nx = phase + 32'd1;
                if (phase == width_cur - 32'd1) begin
                    state_nx = LOW;
                    pps_nx   = 1'b0;
                end
            end
            LOW: begin
                phase_nx = phase + 32'd1;
                if ({1'b0, phase} == per_cur - 33'd1) begin
                    if (en) begin
                        start = 1'b1;
                    end else begin
                        state_nx = IDLE;
                        phase_nx = 32'd0;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                pps_nx   = 1'b0;
                phase_nx = 32'd0;
            end
        endcase

        if (start) begin
            tick_nx      = 1'b1;
            phase_nx     = 32'd0;
            flag_nx      = ~flag;
            sec_cnt_nx   = sec_cnt + 32'd1;
            per_cur_nx   = per_new;
            width_cur_nx = width_new;
            state_nx     = (width_new != 32'd0) ? HIGH : LOW;
            pps_nx       = (width_new != 32'd0);
        end

        // A transfer on a start edge is held for the following second.
        pending_nx = start ? xfer : (pending | xfer);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pps_out     <= 1'b0;
            tick        <= 1'b0;
            flag        <= 1'b0;
            sec_cnt     <= 32'd0;
            phase       <= 32'd0;
            per_cur     <= PERIOD_S;
            width_cur   <= 32'd0;
            pending     <= 1'b0;
            pending_adj <= 32'd0;
        end else begin
            state       <= state_nx;
            pps_out     <= pps_nx;
            tick        <= tick_nx;
            flag        <= flag_nx;
            sec_cnt     <= sec_cnt_nx;
            phase       <= phase_nx;
            per_cur     <= per_cur_nx;
            width_cur   <= width_cur_nx;
            pending     <= pending_nx;
            pending_adj <= pending_adj_nx;
        end
    end

endmodule
